// File: rtl/lr_sgd_trainer.sv
// -----------------------------------------------------------------------------
// lr_sgd_trainer
//   Online linear-regression trainer using stochastic gradient descent in
//   signed fixed point (FRAC fraction bits). For each sample it predicts
//   yhat = sum(x_i*w_i) one feature per cycle. It then forms the scaled error
//   e = (y - yhat) >>> LR_SHIFT, and updates w_i += e*x_i one weight per cycle.
//   A single multiplier is shared by the predict and update phases.
//
//   Optional feature: define LR_SAT_EN to saturate every reduced product,
//   the accumulator, the error and each weight to the signed DW-bit range.
//   Without it, these values wrap modulo 2^DW.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: load w_init / max_epochs and begin training
//   w_init            initial weights, feature i at [i*DW +: DW]
//   max_epochs        number of passes over the dataset (0 = finish at once)
//   samp_valid/ready  sample handshake (ready only while waiting for a sample)
//   samp_x/y/last     sample features, target, end-of-epoch marker
//   wt                current weights, packed like w_init
//   yhat              prediction for the most recent sample
//   busy              high whenever the FSM is not idle
//   done              one-cycle completion pulse
//   epoch_cnt         completed epochs
// -----------------------------------------------------------------------------
module lr_sgd_trainer #(
  parameter int NFEAT    = 4,
  parameter int DW       = 16,
  parameter int FRAC     = 10,
  parameter int LR_SHIFT = 7,
  parameter int EPW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NFEAT*DW-1:0]   w_init,
  input  logic [EPW-1:0]        max_epochs,
  input  logic                  samp_valid,
  output logic                  samp_ready,
  input  logic [NFEAT*DW-1:0]   samp_x,
  input  logic [DW-1:0]         samp_y,
  input  logic                  samp_last,
  output logic [NFEAT*DW-1:0]   wt,
  output logic [DW-1:0]         yhat,
  output logic                  busy,
  output logic                  done,
  output logic [EPW-1:0]        epoch_cnt
);

  localparam int IW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int PW = 2 * DW;

`ifdef LR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [PW-1:0] SMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT, PRED, ERR, UPD, FIN} state_t;

  // Sign-extend a DW-bit value to the wide intermediate width.
  function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  // Reduce a wide intermediate to DW bits: saturate or wrap.
  function automatic logic signed [DW-1:0] fit(input logic signed [PW-1:0] v);
    logic signed [DW-1:0] r;
    r = v[DW-1:0];
    if (SAT_EN) begin
      if (v > SMAX)      r = SMAX[DW-1:0];
      else if (v < SMIN) r = SMIN[DW-1:0];
    end
    return r;
  endfunction

  state_t                state;
  logic [IW-1:0]         idx;
  logic signed [DW-1:0]  w_q [NFEAT];
  logic signed [DW-1:0]  x_q [NFEAT];
  logic signed [DW-1:0]  y_q, acc_q, yhat_q, e_q;
  logic                  last_q;
  logic [EPW-1:0]        max_q, epoch_q;

  logic signed [DW-1:0]  x_cur, w_cur, mul_a, term, acc_sum, w_new, e_next;
  logic signed [PW-1:0]  prod, diff;
  logic [EPW-1:0]        epoch_inc;

  // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
  always_comb begin
    x_cur     = x_q[idx];
    w_cur     = w_q[idx];
    // PRED multiplies x_i*w_i; UPD reuses the same multiplier for e*x_i.
    mul_a     = (state == UPD) ? e_q : w_cur;
    prod      = mul_a * x_cur;
    term      = fit(prod >>> FRAC);
    acc_sum   = fit(sext(acc_q) + sext(term));
    w_new     = fit(sext(w_cur) + sext(term));
    diff      = sext(y_q) - sext(yhat_q);
    e_next    = fit(diff >>> LR_SHIFT);
    epoch_inc = epoch_q + EPW'(1);
  end

  for (genvar g = 0; g < NFEAT; g++) begin : g_wt
    assign wt[g*DW +: DW] = w_q[g];
  end

  assign yhat       = yhat_q;
  assign epoch_cnt  = epoch_q;
  assign samp_ready = (state == WAIT);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      yhat_q  <= '0;
      e_q     <= '0;
      last_q  <= 1'b0;
      max_q   <= '0;
      epoch_q <= '0;
      // NOTE: these small flop arrays are reset on purpose: an abandoned
      // sample must leave no partially updated weight behind.
      for (int i = 0; i < NFEAT; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NFEAT; i++) w_q[i] <= w_init[i*DW +: DW];
            max_q   <= max_epochs;
            epoch_q <= '0;
            yhat_q  <= '0;
            state   <= (max_epochs == '0) ? FIN : WAIT;
          end
        end
        WAIT: begin
          if (samp_valid) begin
            for (int i = 0; i < NFEAT; i++) x_q[i] <= samp_x[i*DW +: DW];
            y_q    <= samp_y;
            last_q <= samp_last;
            acc_q  <= '0;
            idx    <= '0;
            state  <= PRED;
          end
        end
        PRED: begin
          acc_q <= acc_sum;
          if (idx == IW'(NFEAT - 1)) begin
            yhat_q <= acc_sum;
            idx    <= '0;
            state  <= ERR;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ERR: begin
          e_q   <= e_next;
          state <= UPD;
        end
        UPD: begin
          w_q[idx] <= w_new;
          if (idx == IW'(NFEAT - 1)) begin
            idx <= '0;
            if (last_q) begin
              epoch_q <= epoch_inc;
              state   <= (epoch_inc == max_q) ? FIN : WAIT;
            end else begin
              state <= WAIT;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
